const_decoder: RTL and testbench



---
 rtl/const_decoder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_const_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_decoder.sv
// Receive-side constellation decoder: slices tone-ordered (x, y) points to b bits per carrier
// and packs the recovered bit stream LSB-first into fast-path bytes, then interleaved-path bytes.
module const_decoder #(
    parameter int DW        = 8,
    parameter int CONFAW    = 9,
    parameter int CONFDW    = 8,
    parameter int CNUMW     = 8,
    parameter int CONSTW    = 9,
    parameter int TABLELEN  = 256,
    parameter int MAXBITNUM = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CONFAW-1:0] addr_i,
    input  logic              we_conf_i,
    input  logic [CONFDW-1:0] conf_data_i,
    input  logic              xy_valid_i,
    output logic              xy_ready_o,
    input  logic [CNUMW-1:0]  carrier_num_i,
    input  logic [CONSTW-1:0] x_i,
    input  logic [CONSTW-1:0] y_i,
    output logic [DW-1:0]     fast_data_o,
    output logic              fast_valid_o,
    output logic [DW-1:0]     inter_data_o,
    output logic              inter_valid_o,
    output logic              symbol_end_o,
    output logic              err_o
);
    localparam int VW  = MAXBITNUM - (MAXBITNUM % 2);
    localparam int HW  = VW / 2;
    localparam int HBW = $clog2(HW + 1);
    localparam int BLW = $clog2(MAXBITNUM + 1);
    localparam int BCW = CNUMW + 4;
    localparam int FW  = $clog2(DW);
    localparam logic signed [CONSTW-1:0] ONE_S = {{(CONSTW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [CONFDW-1:0]  bit_load_mem [TABLELEN];
    logic [CNUMW-1:0]   used_cfg_q, used_cfg_d, used_lat_q, used_lat_d, used_eff;
    logic [CONFDW-1:0]  fast_cfg_q, fast_cfg_d, fast_lat_q, fast_lat_d;
    logic [CNUMW-1:0]   carrier_cnt_q, carrier_cnt_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d, fast_budget;
    logic [VW-1:0]      shift_q, shift_d, v_bits;
    logic [BLW-1:0]     bits_left_q, bits_left_d;
    logic               last_q, last_d;
    logic               err_q, err_d, symbol_end_q, symbol_end_d;

    logic [CONFDW-1:0]        b_rd;
    logic [HBW-1:0]           h;
    logic                     b_zero, b_ok, accept, is_last;
    logic signed [CONSTW-1:0] vx, vy;
    logic [HW-1:0]            sx, sy;

    logic               push_en, push_sel, push_bit, flush;
    logic [1:0]         partial, valid_all;
    logic [1:0][DW-1:0] byte_all;

    // Clamp to the signed h-bit range and keep the low h bits (upper bits are never emitted).
    function automatic logic [HW-1:0] sat_low(input logic signed [CONSTW-1:0] v,
                                              input logic [HBW-1:0] hh);
        logic signed [CONSTW-1:0] lim;
        logic signed [CONSTW-1:0] s;
        lim = $signed(CONSTW'(1) << (hh - HBW'(1)));
        if (v > lim - ONE_S)
            s = lim - ONE_S;
        else if (v < -lim)
            s = -lim;
        else
            s = v;
        return s[HW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (we_conf_i && (addr_i < CONFAW'(TABLELEN)))
            bit_load_mem[addr_i[CNUMW-1:0]] <= conf_data_i;
    end

    // Symbol parameters come straight from config until the first carrier latches them.
    assign used_eff    = (carrier_cnt_q == '0) ? used_cfg_q : used_lat_q;
    assign xy_ready_o  = (state_q == IDLE) && (used_eff != '0);
    assign accept      = xy_valid_i && xy_ready_o;
    assign is_last     = (carrier_cnt_q == (used_eff - CNUMW'(1)));
    assign fast_budget = BCW'({fast_lat_q, 3'b000});

    assign b_rd   = bit_load_mem[carrier_num_i];
    assign b_zero = (b_rd == '0);
    assign b_ok   = !b_rd[0] && !b_zero && (b_rd <= CONFDW'(MAXBITNUM));
    assign h      = b_rd[HBW:1];
    assign vx     = $signed(x_i) >>> 1;
    assign vy     = $signed(y_i) >>> 1;
    assign sx     = sat_low(vx, h);
    assign sy     = sat_low(vy, h);

    genvar gi;
    generate
        for (gi = 0; gi < HW; gi++) begin : g_map
            assign v_bits[2*gi]   = sy[gi];
            assign v_bits[2*gi+1] = sx[gi];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        used_cfg_d    = used_cfg_q;
        fast_cfg_d    = fast_cfg_q;
        used_lat_d    = used_lat_q;
        fast_lat_d    = fast_lat_q;
        carrier_cnt_d = carrier_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        bits_left_d   = bits_left_q;
        last_d        = last_q;
        err_d         = 1'b0;
        symbol_end_d  = 1'b0;
        push_en       = 1'b0;
        push_sel      = 1'b0;
        push_bit      = shift_q[0];
        flush         = 1'b0;

        if (we_conf_i) begin
            if (addr_i == CONFAW'(TABLELEN))
                used_cfg_d = CNUMW'(conf_data_i);
            else if (addr_i == CONFAW'(TABLELEN + 1))
                fast_cfg_d = conf_data_i;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    carrier_cnt_d = carrier_cnt_q + CNUMW'(1);
                    last_d        = is_last;
                    if (carrier_cnt_q == '0) begin
                        used_lat_d = used_cfg_q;
                        fast_lat_d = fast_cfg_q;
                    end
                    if (b_ok) begin
                        shift_d     = v_bits;
                        bits_left_d = b_rd[BLW-1:0];
                        state_d     = SHIFT;
                    end else begin
                        err_d = !b_zero;
                        if (is_last)
                            state_d = FLUSH;
                    end
                end
            end
            SHIFT: begin
                push_en     = 1'b1;
                push_sel    = (bit_cnt_q >= fast_budget);
                bit_cnt_d   = bit_cnt_q + BCW'(1);
                shift_d     = shift_q >> 1;
                bits_left_d = bits_left_q - BLW'(1);
                if (bits_left_q == BLW'(1))
                    state_d = last_q ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush         = 1'b1;
                err_d         = |partial;
                symbol_end_d  = 1'b1;
                carrier_cnt_d = '0;
                bit_cnt_d     = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            used_cfg_q    <= '0;
            fast_cfg_q    <= '0;
            used_lat_q    <= '0;
            fast_lat_q    <= '0;
            carrier_cnt_q <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            bits_left_q   <= '0;
            last_q        <= 1'b0;
            err_q         <= 1'b0;
            symbol_end_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            used_cfg_q    <= used_cfg_d;
            fast_cfg_q    <= fast_cfg_d;
            used_lat_q    <= used_lat_d;
            fast_lat_q    <= fast_lat_d;
            carrier_cnt_q <= carrier_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            bits_left_q   <= bits_left_d;
            last_q        <= last_d;
            err_q         <= err_d;
            symbol_end_q  <= symbol_end_d;
        end
    end

    // Path 0 is the fast assembler, path 1 the interleaved one.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_asm
            logic [DW-1:0] acc_q, acc_d, data_q, data_d, merged;
            logic [FW-1:0] fill_q, fill_d;
            logic          valid_q, valid_d, take;

            assign take   = push_en && (push_sel == (gi == 1));
            assign merged = acc_q | (DW'(push_bit) << fill_q);

            always_comb begin
                acc_d   = acc_q;
                fill_d  = fill_q;
                data_d  = data_q;
                valid_d = 1'b0;
                if (flush) begin
                    if (fill_q != '0) begin
                        data_d  = acc_q;
                        valid_d = 1'b1;
                    end
                    acc_d  = '0;
                    fill_d = '0;
                end else if (take) begin
                    if (fill_q == FW'(DW - 1)) begin
                        data_d  = merged;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        fill_d  = '0;
                    end else begin
                        acc_d  = merged;
                        fill_d = fill_q + FW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_q   <= '0;
                    fill_q  <= '0;
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    acc_q   <= acc_d;
                    fill_q  <= fill_d;
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign partial[gi]   = (fill_q != '0);
            assign valid_all[gi] = valid_q;
            assign byte_all[gi]  = data_q;
        end
    endgenerate

    assign fast_data_o   = byte_all[0];
    assign fast_valid_o  = valid_all[0];
    assign inter_data_o  = byte_all[1];
    assign inter_valid_o = valid_all[1];
    assign symbol_end_o  = symbol_end_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_const_decoder.sv
// Self-checking bench for const_decoder: directed scenarios plus random symbols compared
// against an arithmetic model of the slicing, bit ordering and fast/interleaved split.
module tb_const_decoder;
    localparam int DW = 8, CONFAW = 9, CONFDW = 8, CNUMW = 8, CONSTW = 9;
    localparam int TLEN = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [CONFAW-1:0] addr_i;
    logic              we_conf_i;
    logic [CONFDW-1:0] conf_data_i;
    logic              xy_valid_i;
    logic              xy_ready_o;
    logic [CNUMW-1:0]  carrier_num_i;
    logic [CONSTW-1:0] x_i, y_i;
    logic [DW-1:0]     fast_data_o, inter_data_o;
    logic              fast_valid_o, inter_valid_o, symbol_end_o, err_o;

    const_decoder dut (
        .clk(clk), .reset(reset), .addr_i(addr_i), .we_conf_i(we_conf_i),
        .conf_data_i(conf_data_i), .xy_valid_i(xy_valid_i), .xy_ready_o(xy_ready_o),
        .carrier_num_i(carrier_num_i), .x_i(x_i), .y_i(y_i),
        .fast_data_o(fast_data_o), .fast_valid_o(fast_valid_o),
        .inter_data_o(inter_data_o), .inter_valid_o(inter_valid_o),
        .symbol_end_o(symbol_end_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int bl_model [TLEN];
    int pt_c[$], pt_x[$], pt_y[$];
    logic [7:0] exp_fast[$], exp_inter[$], got_fast[$], got_inter[$];
    int exp_err = 0, exp_se = 0, got_err = 0, got_se = 0;

    always @(negedge clk) begin
        if (fast_valid_o)  got_fast.push_back(fast_data_o);
        if (inter_valid_o) got_inter.push_back(inter_data_o);
        if (err_o)         got_err++;
        if (symbol_end_o)  got_se++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int floor_half(input int v);
        return (v >= 0) ? v / 2 : -((1 - v) / 2);
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Expected bytes/strobes of one symbol built from the points in pt_*.
    task automatic model_symbol(input int fastb);
        int bits[$];
        int b, hh, lim, sx, sy, acc, n, budget;
        bit part;
        bits = {};
        foreach (pt_c[i]) begin
            b = bl_model[pt_c[i]];
            if (b == 0) continue;
            if ((b % 2) != 0 || b > 15) begin
                exp_err++;
                continue;
            end
            hh  = b / 2;
            lim = 1 << (hh - 1);
            sx  = clamp(floor_half(pt_x[i]), -lim, lim - 1);
            sy  = clamp(floor_half(pt_y[i]), -lim, lim - 1);
            sx  = (sx + 2 * lim) % (2 * lim);
            sy  = (sy + 2 * lim) % (2 * lim);
            for (int k = 0; k < hh; k++) begin
                bits.push_back((sy >> k) & 1);
                bits.push_back((sx >> k) & 1);
            end
        end
        budget = 8 * fastb;
        part   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            acc = 0;
            n   = 0;
            for (int i = 0; i < bits.size(); i++) begin
                if ((i < budget) != (p == 0)) continue;
                acc = acc | (bits[i] << n);
                n++;
                if (n == 8) begin
                    if (p == 0) exp_fast.push_back(8'(acc)); else exp_inter.push_back(8'(acc));
                    acc = 0;
                    n   = 0;
                end
            end
            if (n != 0) begin
                if (p == 0) exp_fast.push_back(8'(acc)); else exp_inter.push_back(8'(acc));
                part = 1'b1;
            end
        end
        if (part) exp_err++;
        exp_se++;
    endtask

    task automatic cfg_write(input int a, input int d);
        @(negedge clk);
        addr_i      = CONFAW'(a);
        conf_data_i = CONFDW'(d);
        we_conf_i   = 1'b1;
        @(negedge clk);
        we_conf_i = 1'b0;
    endtask

    task automatic set_bl(input int c, input int b);
        cfg_write(c, b);
        bl_model[c] = b;
    endtask

    task automatic set_sym(input int used, input int fastb);
        cfg_write(TLEN, used);
        cfg_write(TLEN + 1, fastb);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_point(input int c, input int x, input int y, output int waited);
        carrier_num_i = CNUMW'(c);
        x_i           = CONSTW'(x);
        y_i           = CONSTW'(y);
        xy_valid_i    = 1'b1;
        waited        = 0;
        while (!xy_ready_o && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!xy_ready_o) check_eq("accept_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic play_symbol(input int fastb, input bit gaps);
        int w;
        model_symbol(fastb);
        foreach (pt_c[i]) begin
            send_point(pt_c[i], pt_x[i], pt_y[i], w);
            if (gaps && $urandom_range(0, 2) == 0) begin
                xy_valid_i = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        xy_valid_i = 1'b0;
    endtask

    task automatic clear_all();
        exp_fast = {}; exp_inter = {}; got_fast = {}; got_inter = {};
        exp_err = 0; exp_se = 0; got_err = 0; got_se = 0;
    endtask

    task automatic wait_symbols(input string name, input int f0, input int i0);
        int t = 0;
        while (got_se < exp_se && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        check_eq({name, "_symbol_end"}, got_se, exp_se);
        check_eq({name, "_err"}, got_err, exp_err);
        check_eq({name, "_fast_count"}, got_fast.size(), exp_fast.size());
        check_eq({name, "_inter_count"}, got_inter.size(), exp_inter.size());
        for (int i = 0; i < got_fast.size() && i < exp_fast.size(); i++)
            check_eq($sformatf("%s_fast_byte%0d", name, i), got_fast[i], exp_fast[i]);
        for (int i = 0; i < got_inter.size() && i < exp_inter.size(); i++)
            check_eq($sformatf("%s_inter_byte%0d", name, i), got_inter[i], exp_inter[i]);
        if (f0 >= 0)
            check_eq({name, "_fast_first"}, (got_fast.size() > 0) ? int'(got_fast[0]) : -1, f0);
        if (i0 >= 0)
            check_eq({name, "_inter_first"}, (got_inter.size() > 0) ? int'(got_inter[0]) : -1, i0);
        $display("%s: %0d symbol(s), %0d fast bytes, %0d inter bytes, %0d err cycles",
                 name, got_se, got_fast.size(), got_inter.size(), got_err);
        clear_all();
    endtask

    task automatic load_points(input int n, input int x, input int y);
        pt_c = {}; pt_x = {}; pt_y = {};
        for (int i = 0; i < n; i++) begin
            pt_c.push_back(i); pt_x.push_back(x); pt_y.push_back(y);
        end
    endtask

    task automatic load_random_points(input int n);
        pt_c = {}; pt_x = {}; pt_y = {};
        for (int i = 0; i < n; i++) begin
            pt_c.push_back(i);
            pt_x.push_back(int'($urandom_range(0, 511)) - 256);
            pt_y.push_back(int'($urandom_range(0, 511)) - 256);
        end
    endtask

    initial begin
        int w, used, fastb, r;
        reset = 1'b0; addr_i = '0; we_conf_i = 1'b0; conf_data_i = '0;
        xy_valid_i = 1'b0; carrier_num_i = '0; x_i = '0; y_i = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {fast_data_o, fast_valid_o, inter_data_o, inter_valid_o,
                                   symbol_end_o, err_o, xy_ready_o}, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("ready_unconfigured", xy_ready_o, 0);

        // 1: b=2, (1,-1) x4 -> 0x55
        set_sym(4, 1);
        for (int c = 0; c < 4; c++) set_bl(c, 2);
        load_points(4, 1, -1);
        play_symbol(1, 0);
        wait_symbols("t1", 8'h55, -1);

        // 2: b=4, (3,-3) x4 -> fast 0x66, inter 0x66
        for (int c = 0; c < 4; c++) set_bl(c, 4);
        load_points(4, 3, -3);
        play_symbol(1, 0);
        wait_symbols("t2", 8'h66, 8'h66);

        // 3: saturation -> 0x96
        set_sym(2, 1);
        pt_c = {0, 1}; pt_x = {9, -9}; pt_y = {-9, 9};
        play_symbol(1, 0);
        wait_symbols("t3", 8'h96, -1);

        // 4: b=0 and odd b carriers, partial flush
        set_sym(3, 1);
        set_bl(0, 4); set_bl(1, 0); set_bl(2, 3);
        load_points(3, 3, -3);
        play_symbol(1, 0);
        wait_symbols("t4", 8'h06, -1);

        // 5: backpressure with valid held high across 3 symbols
        set_sym(3, 2);
        for (int c = 0; c < 3; c++) set_bl(c, 14);
        for (int s = 0; s < 3; s++) begin
            load_random_points(3);
            model_symbol(2);
            foreach (pt_c[i]) begin
                send_point(pt_c[i], pt_x[i], pt_y[i], w);
                check_eq($sformatf("t5_wait_s%0d_p%0d", s, i), w,
                         (s == 0 && i == 0) ? 0 : ((i == 0) ? 15 : 14));
            end
        end
        xy_valid_i = 1'b0;
        wait_symbols("t5", -1, -1);

        // 6: asynchronous reset mid-SHIFT
        set_sym(2, 1);
        send_point(0, 101, -77, w);
        xy_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t6_outputs_in_reset", {fast_data_o, fast_valid_o, inter_data_o, inter_valid_o,
                                         symbol_end_o, err_o, xy_ready_o}, 0);
        clear_all();
        @(negedge clk);
        reset = 1'b1;
        xy_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t6_ready_after_reset%0d", i), xy_ready_o, 0);
        end
        xy_valid_i = 1'b0;
        check_eq("t6_no_strobes", got_fast.size() + got_inter.size() + got_se + got_err, 0);
        set_sym(2, 1);
        load_random_points(2);
        play_symbol(1, 0);
        wait_symbols("t6", -1, -1);

        // Random symbols with random loading, budgets and idle gaps
        for (int s = 0; s < 25; s++) begin
            used  = $urandom_range(1, 6);
            fastb = $urandom_range(0, 3);
            set_sym(used, fastb);
            for (int c = 0; c < used; c++) begin
                r = $urandom_range(0, 11);
                if (r == 0)      set_bl(c, 0);
                else if (r == 1) set_bl(c, 2 * $urandom_range(0, 7) + 1);
                else if (r == 2) set_bl(c, 16);
                else             set_bl(c, 2 * $urandom_range(1, 7));
            end
            load_random_points(used);
            play_symbol(fastb, 1);
            wait_symbols($sformatf("rnd%0d", s), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
